// File: rtl/btn_deb_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// btn_deb_ctrl_pkg
//   Shared definitions for the push-button conditioner:
//   - btn_state_e : per-channel hold-tracking FSM encoding (IDLE/HELD/LONG)
//   - DEF_*       : default timing constants for a 12 MHz system clock
//   - cnt_width() : width needed for a counter that must hold values 0..limit
// ---------------------------------------------------------------------------
package btn_deb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } btn_state_e;

  // Defaults sized for 12 MHz: 20 ms debounce, 1 s long press, 200 ms repeat
  localparam int DEF_BTN_WIDTH     = 8;
  localparam int DEF_ACTIVE_LOW    = 1;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_DEB_CYCLES    = 240000;
  localparam int DEF_LONG_CYCLES   = 12000000;
  localparam int DEF_REPEAT_EN     = 1;
  localparam int DEF_REPEAT_CYCLES = 2400000;

  // Counters are sized to hold their limit itself so none of them can wrap
  function automatic int cnt_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/btn_deb_ch.sv
// ---------------------------------------------------------------------------
// btn_deb_ch
//   One button channel: synchroniser, stable-time debouncer, and the
//   press/hold/long/repeat FSM. All outputs are registered.
// Ports
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   pin_i      raw pin, already polarity-normalised (1 = pressed)
//   level_o    debounced level (1 = pressed)
//   press_o    1-cycle pulse in the first cycle level_o reads 1
//   release_o  1-cycle pulse in the first cycle level_o reads 0
//   long_o     1-cycle pulse when the hold reaches LONG_CYCLES
//   rep_o      1-cycle pulse every REPEAT_CYCLES after long_o (if REPEAT_EN)
// ---------------------------------------------------------------------------
module btn_deb_ch
  import btn_deb_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_EN     = DEF_REPEAT_EN,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic rep_o
);

  localparam int DW = cnt_width(DEB_CYCLES);
  localparam int HW = cnt_width(LONG_CYCLES);
  localparam int RW = cnt_width(REPEAT_CYCLES);

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);
  localparam logic          REP_ON    = (REPEAT_EN != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;

  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  logic          level_q, level_d;
  logic          accept, accept_press, accept_release;

  btn_state_e    state_q, state_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RW-1:0] rep_cnt_q, rep_cnt_d;

  logic press_q, press_d;
  logic release_q, release_d;
  logic long_q, long_d;
  logic rep_q, rep_d;

  // Shift the pin through the synchroniser chain. Reset loads the released
  // level so a pin held through reset must still be debounced from scratch.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Debounce: count consecutive cycles where the synchronised pin disagrees
  // with the accepted level. Any agreeing cycle restarts the count, so only
  // a disagreement lasting DEB_CYCLES cycles in a row is accepted. The count
  // clears on acceptance, which keeps it bounded below DEB_CYCLES.
  always_comb begin
    accept    = 1'b0;
    deb_cnt_d = '0;
    level_d   = level_q;
    if (sync_s != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        accept  = 1'b1;
        level_d = sync_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DW'(1);
      end
    end
  end

  assign accept_press   = accept & ~level_q;
  assign accept_release = accept &  level_q;

  // State, counter and output registers. Reset drops everything to idle
  // without emitting a release, even if the button was held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      deb_cnt_q  <= '0;
      level_q    <= 1'b0;
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      deb_cnt_q  <= deb_cnt_d;
      level_q    <= level_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
    end
  end

  // Next-state logic. An accepted release always takes priority, so a
  // long or repeat that would land in the release cycle is dropped. The
  // hold counter steps to LONG_CYCLES on entering LONG and then stays put.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_press) begin
          state_d    = ST_HELD;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end
      end
      ST_HELD: begin
        if (accept_release) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
          if (hold_cnt_q == HOLD_LAST) begin
            state_d   = ST_LONG;
            rep_cnt_d = '0;
          end
        end
      end
      ST_LONG: begin
        if (accept_release) begin
          state_d    = ST_IDLE;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else if (rep_cnt_q == REP_LAST) begin
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        hold_cnt_d = '0;
        rep_cnt_d  = '0;
      end
    endcase
  end

  // Pulse decode. Pulses are computed one cycle early and registered so
  // they line up with the cycle in which level_o / state first change.
  always_comb begin
    press_d   = (state_q == ST_IDLE) && accept_press;
    release_d = (state_q != ST_IDLE) && accept_release;
    long_d    = (state_q == ST_HELD) && !accept_release
                && (hold_cnt_q == HOLD_LAST);
    rep_d     = REP_ON && (state_q == ST_LONG) && !accept_release
                && (rep_cnt_q == REP_LAST);
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign rep_o     = rep_q;

endmodule

// File: rtl/btn_deb_ctrl.sv
// ---------------------------------------------------------------------------
// btn_deb_ctrl
//   Multi-channel push-button conditioner. Normalises pin polarity and
//   hands each pin to an independent btn_deb_ch instance.
// Ports
//   clk          system clock
//   rst          synchronous active-high reset
//   btn_in       raw asynchronous button pins
//   btn_level    debounced state, 1 = pressed
//   btn_press    1-cycle pulse on a debounced 0->1 transition
//   btn_release  1-cycle pulse on a debounced 1->0 transition
//   btn_long     1-cycle pulse when the hold reaches LONG_CYCLES
//   btn_rep      1-cycle pulse every REPEAT_CYCLES while held after btn_long
// ---------------------------------------------------------------------------
module btn_deb_ctrl
  import btn_deb_ctrl_pkg::*;
#(
  parameter int BTN_WIDTH     = DEF_BTN_WIDTH,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_EN     = DEF_REPEAT_EN,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BTN_WIDTH-1:0] btn_in,
  output logic [BTN_WIDTH-1:0] btn_level,
  output logic [BTN_WIDTH-1:0] btn_press,
  output logic [BTN_WIDTH-1:0] btn_release,
  output logic [BTN_WIDTH-1:0] btn_long,
  output logic [BTN_WIDTH-1:0] btn_rep
);

  // Flipping every bit for active-low buttons makes 1 mean pressed inside
  localparam logic [BTN_WIDTH-1:0] POL_MASK = {BTN_WIDTH{ACTIVE_LOW != 0}};

  logic [BTN_WIDTH-1:0] pin_norm;

  assign pin_norm = btn_in ^ POL_MASK;

  // One fully independent conditioner per button
  for (genvar i = 0; i < BTN_WIDTH; i++) begin : g_ch
    btn_deb_ch #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk_i    (clk),
      .rst_i    (rst),
      .pin_i    (pin_norm[i]),
      .level_o  (btn_level[i]),
      .press_o  (btn_press[i]),
      .release_o(btn_release[i]),
      .long_o   (btn_long[i]),
      .rep_o    (btn_rep[i])
    );
  end

endmodule
